// File: rtl/wb_sdram_arbiter.sv
// wb_sdram_arbiter
//
// Two-master Wishbone B3 classic arbiter in front of the single SDRAM controller slave.
// One master owns the slave at a time. Simultaneous requests from idle are
// resolved round-robin. A grant is held for the whole cyc cycle, and at least one
// idle cycle separates consecutive grants.
//
// Optional feature (macro WB_ARB_TIMEOUT_EN): a stall watchdog. When it is enabled, a
// strobe left unanswered for TIMEOUT_CYCLES cycles returns a one-cycle error to the
// granted master. The slave is then kept off the bus until that master drops cyc.
// When the macro is undefined, err is a pure pass-through of s_err_i.
//
// Ports
//   wb_clk, wb_rst_n          clock, asynchronous active-low reset
//   mN_cyc/stb/we/sel/adr/dat_i  master N (N = 0, 1) request
//   mN_dat_o                  read data (s_dat_i, shared by both masters)
//   mN_ack_o, mN_err_o        termination, only to the granted master
//   s_cyc/stb/we/sel/adr/dat_o   request to the slave; all zero while no master is granted
//   s_dat_i, s_ack_i, s_err_i    slave response

module wb_sdram_arbiter #(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            wb_clk,
  input  logic            wb_rst_n,

  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,

  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,

  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i
);

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : gen_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  // StHold can only be reached after a watchdog timeout. In that state the slave is
  // kept idle until the master that timed out (recorded in last_q) releases cyc.
  typedef enum logic [1:0] {StIdle, StGnt0, StGnt1, StHold} state_e;

  state_e state_q, state_d;
  logic   last_q, last_d;   // most recently granted master; reset to 1 so m0 wins first tie
  logic   granted;
  logic   tmo;              // watchdog firing in this cycle

  assign granted = (state_q == StGnt0) || (state_q == StGnt1);

  // State register
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] TmoLimit = 16'(TIMEOUT_CYCLES);

  logic [15:0] cnt_q, cnt_d;

  // Counts strobe cycles that are still waiting for a response. The counter holds its
  // value across bus-lock gaps (stb low), and restarts on any response or when the
  // grant ends.
  always_comb begin
    cnt_d = '0;
    if (granted && !tmo) begin
      if (s_ack_i || s_err_i) begin
        cnt_d = '0;
      end else if (s_stb_o) begin
        cnt_d = cnt_q + 16'd1;
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Derived only from registered state, so the grant logic never depends
  // combinationally on the slave.
  assign tmo = granted && (cnt_q >= TmoLimit);
`else
  assign tmo = 1'b0;
`endif

  // Next-state logic. It looks only at the master cyc lines and the registered state.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_q ? StGnt0 : StGnt1;
          last_d  = ~last_q;
        end else if (m0_cyc_i) begin
          state_d = StGnt0;
          last_d  = 1'b0;
        end else if (m1_cyc_i) begin
          state_d = StGnt1;
          last_d  = 1'b1;
        end
      end
      StGnt0: begin
        if (tmo) begin
          state_d = StHold;
        end else if (!m0_cyc_i) begin
          state_d = StIdle;
        end
      end
      StGnt1: begin
        if (tmo) begin
          state_d = StHold;
        end else if (!m1_cyc_i) begin
          state_d = StIdle;
        end
      end
      StHold: begin
        if (!(last_q ? m1_cyc_i : m0_cyc_i)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output mux. The granted master is connected straight through. In every other state
  // the slave sees an all-zero request and neither master gets ack or err.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    unique case (state_q)
      StGnt0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i | tmo;
      end
      StGnt1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i | tmo;
      end
      default: ;
    endcase
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule
